// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution sequencer: state encoding and
// default sizing parameters.
package cpu_ctrl_pkg;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAST = 2'd2,
    ST_EDIT = 2'd3
  } state_e;

  localparam int RUN_DIV_DEF = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/run_controller_if.sv
// Panel-control and ROM-write bundle between the front panel / CPU core
// and the execution sequencer.
interface run_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              NEXT;
  logic              RUN;
  logic              SPEEDRUN;
  logic              edit;
  logic              send;
  logic [ADDR_W-1:0] unit;
  logic [DATA_W-1:0] code;
  logic              halt;
  logic              step_en;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              running;
  logic [1:0]        state;
  logic [CNT_W-1:0]  step_count;

  // Sequencer side.
  modport slave (
    input  NEXT, RUN, SPEEDRUN, edit, send, unit, code, halt,
    output step_en, rom_we, rom_addr, rom_data, running, state, step_count
  );

  // Panel / core side.
  modport master (
    output NEXT, RUN, SPEEDRUN, edit, send, unit, code, halt,
    input  step_en, rom_we, rom_addr, rom_data, running, state, step_count
  );
endinterface

// File: rtl/edge_detect.sv
// One-bit registered rising-edge detector. press_o is high in the cycle
// where d_i is high and was low at the previous clock edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic press_o
);
  logic d_q;

  // Remember the input level from the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d_i;
  end

  assign press_o = d_i & ~d_q;
endmodule

// File: rtl/run_controller.sv
// Execution sequencer: converts panel NEXT/RUN/SPEEDRUN presses into a
// single-cycle step_en strobe and issues ROM write strobes in edit mode.
module run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int RUN_DIV = RUN_DIV_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  run_controller_if.slave bus
);
  localparam int PW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(RUN_DIV - 1);

  logic next_p, run_p, speed_p, send_p;

  edge_detect u_ed_next  (.clk(clk), .rst(rst), .d_i(bus.NEXT),     .press_o(next_p));
  edge_detect u_ed_run   (.clk(clk), .rst(rst), .d_i(bus.RUN),      .press_o(run_p));
  edge_detect u_ed_speed (.clk(clk), .rst(rst), .d_i(bus.SPEEDRUN), .press_o(speed_p));
  edge_detect u_ed_send  (.clk(clk), .rst(rst), .d_i(bus.send),     .press_o(send_p));

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              step_en_q, step_en_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rom_data_q, rom_data_d;
  logic              running_q, running_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Next-state and strobe decode; every output is computed here and registered below.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    step_en_d  = 1'b0;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.edit) begin
          state_d = ST_EDIT;
        end else if (speed_p && !bus.halt) begin
          state_d = ST_FAST;
        end else if (run_p && !bus.halt) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (next_p && !bus.halt) begin
          step_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Exit takes precedence over a terminal count on the same edge.
        if (bus.halt || run_p || speed_p) begin
          state_d = ST_IDLE;
        end else if (presc_q == PRESC_TERM) begin
          presc_d   = '0;
          step_en_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_FAST: begin
        if (bus.halt || run_p || speed_p) state_d   = ST_IDLE;
        else                                 step_en_d = 1'b1;
      end
      ST_EDIT: begin
        // Leaving edit mode wins over a coincident send press.
        if (!bus.edit) begin
          state_d = ST_IDLE;
        end else if (send_p) begin
          rom_we_d   = 1'b1;
          rom_addr_d = bus.unit;
          rom_data_d = bus.code;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN) || (state_d == ST_FAST);
    count_d   = (step_en_d && (count_q != {CNT_W{1'b1}})) ? count_q + 1'b1 : count_q;
  end

  // State, prescaler, strobes and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      step_en_q  <= 1'b0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      running_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      step_en_q  <= step_en_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      running_q  <= running_d;
      count_q    <= count_d;
    end
  end

  assign bus.step_en    = step_en_q;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.running    = running_q;
  assign bus.state      = state_q;
  assign bus.step_count = count_q;
endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus a
// randomized run compared against a behavioural model.
module tb_run_controller;
  localparam int RUN_DIV = 4;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  run_controller_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) bus ();

  run_controller #(.RUN_DIV(RUN_DIV), .ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: mode 0 idle, 1 run, 2 fast, 3 edit.
  int          m_mode;
  int          m_age;
  bit          m_step, m_we;
  logic [7:0]  m_addr, m_data;
  int          m_count;
  bit          p_next, p_run, p_speed, p_send;

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_step = 0; m_we = 0;
    m_addr = 8'h00; m_data = 8'h00; m_count = 0;
    p_next = 0; p_run = 0; p_speed = 0; p_send = 0;
  endtask

  task automatic model_step();
    bit pn, pr, ps, pse, nstep;
    pn  = bus.NEXT && !p_next;
    pr  = bus.RUN && !p_run;
    ps  = bus.SPEEDRUN && !p_speed;
    pse = bus.send && !p_send;
    nstep = 0;
    m_we  = 0;
    case (m_mode)
      0: begin
        if (bus.edit) m_mode = 3;
        else if (!bus.halt && ps) m_mode = 2;
        else if (!bus.halt && pr) begin m_mode = 1; m_age = 0; end
        else if (!bus.halt && pn) nstep = 1;
      end
      1: begin
        if (bus.halt || pr || ps) m_mode = 0;
        else begin
          m_age++;
          nstep = ((m_age % RUN_DIV) == 0);
        end
      end
      2: begin
        if (bus.halt || pr || ps) m_mode = 0;
        else nstep = 1;
      end
      default: begin
        if (!bus.edit) m_mode = 0;
        else if (pse) begin m_we = 1; m_addr = bus.unit; m_data = bus.code; end
      end
    endcase
    m_step = nstep;
    if (nstep && m_count < 65535) m_count++;
    p_next = bus.NEXT; p_run = bus.RUN; p_speed = bus.SPEEDRUN; p_send = bus.send;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1;
  endtask

  task automatic clear_inputs();
    bus.NEXT = 0; bus.RUN = 0; bus.SPEEDRUN = 0; bus.edit = 0;
    bus.send = 0; bus.halt = 0; bus.unit = 8'h00; bus.code = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.NEXT = 1; bus.RUN = 1; bus.SPEEDRUN = 1; bus.edit = 1;
    bus.send = 1; bus.halt = 1; bus.unit = 8'hFF; bus.code = 8'hFF;
    model_reset();
    repeat (3) tick();
    n_cmp++; if (bus.step_en !== 1'b0) begin n_bad++; $display("FAIL reset_step_en: got %0b want 0", bus.step_en); end
    n_cmp++; if (bus.rom_we !== 1'b0) begin n_bad++; $display("FAIL reset_rom_we: got %0b want 0", bus.rom_we); end
    n_cmp++; if (bus.rom_addr !== 8'h00) begin n_bad++; $display("FAIL reset_rom_addr: got %h want 00", bus.rom_addr); end
    n_cmp++; if (bus.rom_data !== 8'h00) begin n_bad++; $display("FAIL reset_rom_data: got %h want 00", bus.rom_data); end
    n_cmp++; if (bus.running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %0b want 0", bus.running); end
    n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.step_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.step_count); end
    clear_inputs();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.state !== 2'd0 || bus.step_en !== 1'b0) begin
        n_bad++; $display("FAIL post_reset_idle: got state=%0d step_en=%0b want 0/0", bus.state, bus.step_en);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_next();
    int pulses = 0;
    bus.NEXT = 1;
    repeat (10) begin tick(); if (bus.step_en) pulses++; end
    bus.NEXT = 0;
    tick();
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL next_pulses: got %0d want 1", pulses); end
    n_cmp++; if (bus.step_count !== 16'd1) begin n_bad++; $display("FAIL next_count: got %0d want 1", bus.step_count); end
    $display("test_next pulses=%0d count=%0d", pulses, bus.step_count);
  endtask

  task automatic test_run();
    logic [31:0] seen = '0;
    logic [31:0] want = '0;
    want[4] = 1'b1; want[8] = 1'b1; want[12] = 1'b1;
    bus.RUN = 1;
    tick();
    bus.RUN = 0;
    n_cmp++; if (bus.running !== 1'b1 || bus.state !== 2'd1) begin n_bad++; $display("FAIL run_entry: got running=%0b state=%0d want 1/1", bus.running, bus.state); end
    for (int i = 1; i < 24; i++) begin
      if (i == 14) bus.RUN = 1;
      tick();
      if (i == 14) bus.RUN = 0;
      if (bus.step_en) seen[i] = 1'b1;
    end
    n_cmp++; if (seen !== want) begin n_bad++; $display("FAIL run_pulse_cycles: got %h want %h", seen, want); end
    n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL run_exit_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.step_count !== 16'd4) begin n_bad++; $display("FAIL run_count: got %0d want 4", bus.step_count); end
    $display("test_run pulse map=%h", seen);
  endtask

  task automatic test_speedrun_halt();
    int pulses = 0;
    int guard = 0;
    int late = 0;
    bus.SPEEDRUN = 1;
    tick();
    bus.SPEEDRUN = 0;
    while (pulses < 5 && guard < 40) begin
      tick(); guard++;
      if (bus.step_en) pulses++;
    end
    bus.halt = 1;
    tick();
    n_cmp++; if (pulses != 5) begin n_bad++; $display("FAIL fast_pulses: got %0d want 5 (in %0d cycles)", pulses, guard); end
    n_cmp++; if (guard != 5) begin n_bad++; $display("FAIL fast_latency: got %0d cycles want 5", guard); end
    n_cmp++; if (bus.step_en !== 1'b0 || bus.state !== 2'd0) begin n_bad++; $display("FAIL halt_exit: got step_en=%0b state=%0d want 0/0", bus.step_en, bus.state); end
    n_cmp++; if (bus.step_count !== 16'd9) begin n_bad++; $display("FAIL fast_count: got %0d want 9", bus.step_count); end
    bus.NEXT = 1; tick(); if (bus.step_en) late++;
    bus.NEXT = 0; bus.RUN = 1; tick(); if (bus.step_en) late++;
    bus.RUN = 0;
    repeat (6) begin tick(); if (bus.step_en) late++; end
    n_cmp++; if (late != 0 || bus.state !== 2'd0) begin n_bad++; $display("FAIL halt_blocks: got pulses=%0d state=%0d want 0/0", late, bus.state); end
    bus.halt = 0;
    tick();
    $display("test_speedrun_halt pulses=%0d count=%0d", pulses, bus.step_count);
  endtask

  task automatic test_edit();
    bus.edit = 1;
    tick();
    n_cmp++; if (bus.state !== 2'd3) begin n_bad++; $display("FAIL edit_entry: got %0d want 3", bus.state); end
    bus.unit = 8'h03; bus.code = 8'hA5; bus.send = 1;
    tick();
    n_cmp++; if (bus.rom_we !== 1'b1) begin n_bad++; $display("FAIL edit_we: got %0b want 1", bus.rom_we); end
    n_cmp++; if (bus.rom_addr !== 8'h03 || bus.rom_data !== 8'hA5) begin n_bad++; $display("FAIL edit_addr_data: got %h/%h want 03/a5", bus.rom_addr, bus.rom_data); end
    bus.send = 0; bus.unit = 8'h77; bus.code = 8'h11;
    tick();
    n_cmp++; if (bus.rom_we !== 1'b0 || bus.rom_addr !== 8'h03 || bus.rom_data !== 8'hA5) begin n_bad++; $display("FAIL edit_hold: got we=%0b %h/%h want 0 03/a5", bus.rom_we, bus.rom_addr, bus.rom_data); end
    n_cmp++; if (bus.step_en !== 1'b0) begin n_bad++; $display("FAIL edit_step: got %0b want 0", bus.step_en); end
    bus.edit = 0; bus.send = 1;
    tick();
    bus.send = 0;
    n_cmp++; if (bus.state !== 2'd0 || bus.rom_we !== 1'b0) begin n_bad++; $display("FAIL edit_exit: got state=%0d we=%0b want 0/0", bus.state, bus.rom_we); end
    $display("test_edit addr=%h data=%h", bus.rom_addr, bus.rom_data);
  endtask

  task automatic test_priority_reset();
    bus.RUN = 1; bus.SPEEDRUN = 1; bus.NEXT = 1;
    tick();
    n_cmp++; if (bus.state !== 2'd2 || bus.running !== 1'b1) begin n_bad++; $display("FAIL prio_fast: got state=%0d running=%0b want 2/1", bus.state, bus.running); end
    tick();
    n_cmp++; if (bus.step_en !== 1'b1) begin n_bad++; $display("FAIL prio_step: got %0b want 1", bus.step_en); end
    #3 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.step_en !== 1'b0 || bus.state !== 2'd0 || bus.running !== 1'b0) begin n_bad++; $display("FAIL async_reset: got step_en=%0b state=%0d running=%0b want 0/0/0", bus.step_en, bus.state, bus.running); end
    n_cmp++; if (bus.step_count !== 16'd0) begin n_bad++; $display("FAIL async_reset_count: got %0d want 0", bus.step_count); end
    clear_inputs();
    tick(); tick();
    rst = 1'b1;
    tick();
    $display("test_priority_reset done");
  endtask

  task automatic test_random();
    int shown = 0;
    int bad0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7, 0) == 0) bus.NEXT = ~bus.NEXT;
      if ($urandom_range(11, 0) == 0) bus.RUN = ~bus.RUN;
      if ($urandom_range(15, 0) == 0) bus.SPEEDRUN = ~bus.SPEEDRUN;
      if ($urandom_range(3, 0) == 0) bus.send = ~bus.send;
      if ($urandom_range(29, 0) == 0) bus.edit = ~bus.edit;
      if ($urandom_range(39, 0) == 0) bus.halt = ~bus.halt;
      bus.unit = 8'($urandom);
      bus.code = 8'($urandom);
      tick();
      bad0 = n_bad;
      n_cmp++; if (bus.state !== 2'(m_mode)) n_bad++;
      n_cmp++; if (bus.step_en !== m_step) n_bad++;
      n_cmp++; if (bus.running !== (m_mode == 1 || m_mode == 2)) n_bad++;
      n_cmp++; if (bus.rom_we !== m_we) n_bad++;
      n_cmp++; if (bus.rom_addr !== m_addr || bus.rom_data !== m_data) n_bad++;
      n_cmp++; if (bus.step_count !== 16'(m_count)) n_bad++;
      if (n_bad != bad0 && shown < 20) begin
        shown++;
        $display("FAIL rand_cycle %0d: got st=%0d se=%0b run=%0b we=%0b a=%h d=%h cnt=%0d want st=%0d se=%0b we=%0b a=%h d=%h cnt=%0d",
                 c, bus.state, bus.step_en, bus.running, bus.rom_we, bus.rom_addr, bus.rom_data, bus.step_count,
                 m_mode, m_step, m_we, m_addr, m_data, m_count);
      end
    end
    $display("test_random done steps=%0d", m_count);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_next();
    test_run();
    test_speedrun_halt();
    test_edit();
    test_priority_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
